pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Instruction-fetch sequencer for the RISC core: owns the PC, issues one fetch
//  at a time to instruction memory over a req/ack handshake, and hands each
//  instruction to decode over a valid/ready handshake. It resolves branches
//  internally using the core's 2-bit condition encoding and redirects the PC.
//  On a taken branch it flushes or discards in-flight fetches. Sits between
//  imem and decode.
// PARAMETERS
//  WIDTH     32  data/address width (PC, instruction, branch operand, target)
//  RESET_PC  0   PC value loaded on reset
//  PC_STEP   4   PC increment per accepted instruction
// PORTS
//  clk          in   1      clock, all state on rising edge
//  rst_n        in   1      asynchronous active-low reset
//  imem_req     out  1      fetch request; held until imem_ack
//  imem_addr    out  WIDTH  fetch address; stable while imem_req=1
//  imem_ack     in   1      1-cycle pulse: imem_rdata valid this cycle
//  imem_rdata   in   WIDTH  fetched instruction word
//  instr_valid  out  1      instr/instr_pc valid for decode
//  instr        out  WIDTH  instruction to decode
//  instr_pc     out  WIDTH  PC of instr
//  instr_ready  in   1      decode accepts instr when instr_valid&instr_ready
//  br_valid     in   1      branch resolve request from execute (1 cycle)
//  br_cond      in   2      0=always, 1=less (A<0), 2=greater (A>0), 3=equal (A==0)
//  br_operand   in   WIDTH  A, compared as SIGNED two's complement against 0
//  br_target    in   WIDTH  redirect PC
//  br_taken     out  1      registered 1-cycle pulse: branch taken last cycle
//  halt         in   1      level: stop fetching at next fetch boundary
//  pc           out  WIDTH  current PC (next address to fetch)
// BEHAVIOUR
//  Reset (async, immediate): state=BOOT, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC,
//   instr_valid=0, instr=0, instr_pc=0, br_taken=0, redirect_pend=0. Outputs registered.
//  States: BOOT, FETCH, ISSUE, HALT.
//  "Enter-fetch" = go to HALT if halt=1, else FETCH with imem_req=1, imem_addr=pc_next.
//  BOOT: unconditionally enter-fetch on first edge after rst_n rises.
//  FETCH: imem_req=1 until ack; addr never changes while req=1.
//   ack & !redirect_pend & !taken: instr<=imem_rdata, instr_pc<=imem_addr,
//    instr_valid<=1, imem_req<=0, ->ISSUE. Latency ack->instr_valid = 1 cycle.
//   ack & (redirect_pend | taken): discard data, clear redirect_pend, enter-fetch at new pc.
//   taken without ack: pc<=br_target, redirect_pend<=1, stay (req/addr held).
//  ISSUE: instr_valid held with stable instr until accepted.
//   accept & !taken: pc<=pc+PC_STEP (mod 2^WIDTH, wraps), instr_valid<=0, enter-fetch.
//   taken (with or without accept): pc<=br_target, instr_valid<=0 (flush), enter-fetch
//    at br_target; branch wins over accept, no PC_STEP applied.
//  HALT: no requests, instr_valid=0. taken: pc<=br_target. halt=0: enter-fetch at pc.
//  taken = br_valid & cond_true; cond_true per br_cond using signed A; cond 0 always 1.
//   br_taken<=taken every cycle in any state; br_valid & !cond_true: no state effect.
//  halt is only sampled at enter-fetch; a pending fetch or issued instr completes.
//  br_valid in BOOT is ignored.
//  rst_n low mid-handshake: imem_req drops asynchronously; imem must drop the
//   outstanding request.
// TESTING
//  Reset then imem acks after 2 cycles with 0x11, ready=1 -> instr_pc=0, instr=0x11;
//   next imem_addr=4, then 8; instr_valid low between issues.
//  ISSUE with instr_ready=0 for 5 cycles -> instr/instr_pc stable, pc unchanged, no imem_req.
//  br_valid, cond=1, A=0xFFFFFFFF(-1), target=0x100 while ISSUE -> instr flushed,
//   br_taken pulse, next imem_addr=0x100; same with cond=2 -> no redirect, br_taken=0.
//  Taken branch (cond=3, A=0) during FETCH with ack 3 cycles later -> returned word
//   discarded (no instr_valid), next fetch addr=target.
//  halt=1 before accept -> after accept no imem_req; branch to 0x40 in HALT; halt=0 ->
//   fetch at 0x40. Also pc=0xFFFFFFFC accepted -> pc wraps to 0.
//  rst_n pulsed low while imem_req=1 -> imem_req, instr_valid drop same cycle, pc=RESET_PC.

Source files
------------

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - instruction-fetch sequencer: owns the PC, one imem fetch at a time,
// hands instructions to decode and resolves branches internally with fetch discard/flush.
module pc_sequencer #(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int unsigned      PC_STEP  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ack,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic             instr_valid,
  output logic [WIDTH-1:0] instr,
  output logic [WIDTH-1:0] instr_pc,
  input  logic             instr_ready,
  input  logic             br_valid,
  input  logic [1:0]       br_cond,
  input  logic [WIDTH-1:0] br_operand,
  input  logic [WIDTH-1:0] br_target,
  output logic             br_taken,
  input  logic             halt,
  output logic [WIDTH-1:0] pc
);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_ISSUE = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] LP_STEP = WIDTH'(PC_STEP);

  state_t           r_state, w_state_n;
  logic [WIDTH-1:0] r_pc, w_pc_n;
  logic [WIDTH-1:0] r_imem_addr, w_imem_addr_n;
  logic [WIDTH-1:0] r_instr, w_instr_n;
  logic [WIDTH-1:0] r_instr_pc, w_instr_pc_n;
  logic             r_imem_req, w_imem_req_n;
  logic             r_instr_valid, w_instr_valid_n;
  logic             r_redirect_pend, w_redirect_pend_n;
  logic             r_br_taken;
  logic             w_cond_true, w_taken, w_accept;
  logic             w_enter_fetch;
  logic [WIDTH-1:0] w_fetch_addr;

  // Operand is signed two's complement; the sign bit alone decides "less than zero".
  always_comb begin
    w_cond_true = 1'b0;
    case (br_cond)
      2'd0: w_cond_true = 1'b1;
      2'd1: w_cond_true = br_operand[WIDTH-1];
      2'd2: w_cond_true = !br_operand[WIDTH-1] && (br_operand != '0);
      2'd3: w_cond_true = (br_operand == '0);
      default: w_cond_true = 1'b0;
    endcase
  end

  assign w_taken  = br_valid && w_cond_true && (r_state != S_BOOT);
  assign w_accept = r_instr_valid && instr_ready;

  always_comb begin
    w_state_n         = r_state;
    w_pc_n            = r_pc;
    w_imem_req_n      = r_imem_req;
    w_imem_addr_n     = r_imem_addr;
    w_instr_valid_n   = r_instr_valid;
    w_instr_n         = r_instr;
    w_instr_pc_n      = r_instr_pc;
    w_redirect_pend_n = r_redirect_pend;
    w_enter_fetch     = 1'b0;
    w_fetch_addr      = r_pc;

    unique case (r_state)
      S_BOOT: begin
        w_enter_fetch = 1'b1;
        w_fetch_addr  = r_pc;
      end
      S_FETCH: begin
        if (imem_ack) begin
          if (!r_redirect_pend && !w_taken) begin
            w_instr_n       = imem_rdata;
            w_instr_pc_n    = r_imem_addr;
            w_instr_valid_n = 1'b1;
            w_imem_req_n    = 1'b0;
            w_state_n       = S_ISSUE;
          end else begin
            // Returned word belongs to the stale path; refetch from the redirected PC.
            w_redirect_pend_n = 1'b0;
            if (w_taken) begin
              w_pc_n = br_target;
            end
            w_enter_fetch = 1'b1;
            w_fetch_addr  = w_taken ? br_target : r_pc;
          end
        end else if (w_taken) begin
          w_pc_n            = br_target;
          w_redirect_pend_n = 1'b1;
        end
      end
      S_ISSUE: begin
        if (w_taken) begin
          w_pc_n          = br_target;
          w_instr_valid_n = 1'b0;
          w_enter_fetch   = 1'b1;
          w_fetch_addr    = br_target;
        end else if (w_accept) begin
          w_pc_n          = r_pc + LP_STEP;
          w_instr_valid_n = 1'b0;
          w_enter_fetch   = 1'b1;
          w_fetch_addr    = r_pc + LP_STEP;
        end
      end
      S_HALT: begin
        if (w_taken) begin
          w_pc_n = br_target;
        end
        if (!halt) begin
          w_enter_fetch = 1'b1;
          w_fetch_addr  = w_taken ? br_target : r_pc;
        end
      end
      default: begin
        w_state_n = S_BOOT;
      end
    endcase

    if (w_enter_fetch) begin
      if (halt) begin
        w_state_n    = S_HALT;
        w_imem_req_n = 1'b0;
      end else begin
        w_state_n     = S_FETCH;
        w_imem_req_n  = 1'b1;
        w_imem_addr_n = w_fetch_addr;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= S_BOOT;
      r_pc            <= RESET_PC;
      r_imem_req      <= 1'b0;
      r_imem_addr     <= RESET_PC;
      r_instr_valid   <= 1'b0;
      r_instr         <= '0;
      r_instr_pc      <= '0;
      r_br_taken      <= 1'b0;
      r_redirect_pend <= 1'b0;
    end else begin
      r_state         <= w_state_n;
      r_pc            <= w_pc_n;
      r_imem_req      <= w_imem_req_n;
      r_imem_addr     <= w_imem_addr_n;
      r_instr_valid   <= w_instr_valid_n;
      r_instr         <= w_instr_n;
      r_instr_pc      <= w_instr_pc_n;
      r_br_taken      <= w_taken;
      r_redirect_pend <= w_redirect_pend_n;
    end
  end

  assign imem_req    = r_imem_req;
  assign imem_addr   = r_imem_addr;
  assign instr_valid = r_instr_valid;
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign br_taken    = r_br_taken;
  assign pc          = r_pc;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - scoreboard bench for pc_sequencer: fetch addresses, issued
// instructions and taken-branch pulses are queued up front and popped by a monitor.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        br_valid;
  logic [1:0]  br_cond;
  logic [31:0] br_operand;
  logic [31:0] br_target;
  logic        br_taken;
  logic        halt;
  logic [31:0] pc;

  int checks   = 0;
  int failures = 0;
  int n_accept = 0;
  int lat      = 2;

  logic [31:0] q_addr[$];
  logic [63:0] q_instr[$];
  logic [31:0] q_br[$];

  pc_sequencer #(.WIDTH(32), .RESET_PC(32'h0), .PC_STEP(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instr_valid(instr_valid),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .instr_ready(instr_ready),
    .br_valid   (br_valid),
    .br_cond    (br_cond),
    .br_operand (br_operand),
    .br_target  (br_target),
    .br_taken   (br_taken),
    .halt       (halt),
    .pc         (pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_valid(input string name);
    int k = 0;
    while (!instr_valid && k < 60) begin
      cyc(1);
      k++;
    end
    checks++;
    if (!instr_valid) begin
      failures++;
      $display("FAIL %s timeout: instr_valid=0 expected 1", name);
    end
  endtask

  task automatic wait_accepts(input int target, input string name);
    int k = 0;
    while (n_accept < target && k < 120) begin
      @(negedge clk);
      #1;
      k++;
    end
    checks++;
    if (n_accept < target) begin
      failures++;
      $display("FAIL %s timeout: accepts=%0d expected %0d", name, n_accept, target);
    end
    @(posedge clk);
    #1;
  endtask

  // imem model: acks `lat` cycles after a request appears, data = addr + 0x11.
  initial begin : imem_model
    int cnt;
    cnt        = 0;
    imem_ack   = 1'b0;
    imem_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      imem_ack = 1'b0;
      if (!imem_req) begin
        cnt = 0;
      end else begin
        cnt++;
        if (cnt >= lat) begin
          imem_ack   = 1'b1;
          imem_rdata = imem_addr + 32'h11;
          cnt        = 0;
        end
      end
    end
  end

  initial begin : monitor
    logic        prev_req;
    logic        prev_ack;
    logic        prev_accept;
    logic [63:0] e;
    logic [31:0] a;
    prev_req    = 1'b0;
    prev_ack    = 1'b0;
    prev_accept = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_req    = 1'b0;
        prev_ack    = 1'b0;
        prev_accept = 1'b0;
      end else begin
        if (prev_accept) chk("valid_low_after_accept", 32'(instr_valid), 32'h0);
        if (imem_req && (!prev_req || prev_ack)) begin
          if (q_addr.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_fetch: addr=%h expected no request", imem_addr);
          end else begin
            a = q_addr.pop_front();
            chk("fetch_addr", imem_addr, a);
          end
        end
        if (instr_valid && instr_ready) begin
          n_accept++;
          if (q_instr.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_instr: pc=%h instr=%h expected none", instr_pc, instr);
          end else begin
            e = q_instr.pop_front();
            chk("instr_pc", instr_pc, e[63:32]);
            chk("instr", instr, e[31:0]);
          end
        end
        if (br_taken) begin
          if (q_br.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_br_taken: pc=%h expected no pulse", pc);
          end else begin
            a = q_br.pop_front();
            chk("br_redirect_pc", pc, a);
          end
        end
        prev_req    = imem_req;
        prev_ack    = imem_ack;
        prev_accept = instr_valid && instr_ready;
      end
    end
  end

  initial begin : stimulus
    rst_n       = 1'b0;
    instr_ready = 1'b1;
    br_valid    = 1'b0;
    br_cond     = 2'd0;
    br_operand  = '0;
    br_target   = '0;
    halt        = 1'b0;
    cyc(3);
    chk("rst_imem_req", 32'(imem_req), 32'h0);
    chk("rst_imem_addr", imem_addr, 32'h0);
    chk("rst_instr_valid", 32'(instr_valid), 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst_br_taken", 32'(br_taken), 32'h0);
    chk("rst_pc", pc, 32'h0);

    // Sequential fetch 0, 4, 8 with decode always ready.
    q_addr.push_back(32'h0);  q_instr.push_back({32'h0, 32'h11});
    q_addr.push_back(32'h4);  q_instr.push_back({32'h4, 32'h15});
    q_addr.push_back(32'h8);  q_instr.push_back({32'h8, 32'h19});
    q_addr.push_back(32'hC);
    rst_n = 1'b1;
    wait_accepts(3, "basic_fetch");

    // Decode stalls on the instruction at 0xC.
    instr_ready = 1'b0;
    wait_valid("stall_valid");
    repeat (5) begin
      cyc(1);
      chk("stall_valid", 32'(instr_valid), 32'h1);
      chk("stall_instr", instr, 32'h1D);
      chk("stall_instr_pc", instr_pc, 32'hC);
      chk("stall_pc", pc, 32'hC);
      chk("stall_no_req", 32'(imem_req), 32'h0);
    end

    // cond=1 with A=-1 is taken: flush and redirect to 0x100.
    q_br.push_back(32'h100);
    q_addr.push_back(32'h100);
    br_valid = 1'b1; br_cond = 2'd1; br_operand = 32'hFFFF_FFFF; br_target = 32'h100;
    cyc(1);
    br_valid = 1'b0;
    chk("flush_valid", 32'(instr_valid), 32'h0);
    chk("flush_br_taken", 32'(br_taken), 32'h1);
    chk("flush_req", 32'(imem_req), 32'h1);
    chk("flush_addr", imem_addr, 32'h100);

    // cond=2 with A=-1 is not taken: no effect.
    wait_valid("redirect_valid");
    chk("redirect_instr_pc", instr_pc, 32'h100);
    chk("redirect_instr", instr, 32'h111);
    br_valid = 1'b1; br_cond = 2'd2; br_operand = 32'hFFFF_FFFF; br_target = 32'h300;
    cyc(1);
    br_valid = 1'b0;
    chk("nt_valid", 32'(instr_valid), 32'h1);
    chk("nt_instr_pc", instr_pc, 32'h100);
    chk("nt_br_taken", 32'(br_taken), 32'h0);
    chk("nt_pc", pc, 32'h100);

    // Taken branch during a fetch; ack arrives 3 cycles later and is discarded.
    lat = 4;
    q_instr.push_back({32'h100, 32'h111});
    q_addr.push_back(32'h104);
    instr_ready = 1'b1;
    wait_accepts(4, "accept_100");
    q_br.push_back(32'h200);
    q_addr.push_back(32'h200);
    br_valid = 1'b1; br_cond = 2'd3; br_operand = 32'h0; br_target = 32'h200;
    instr_ready = 1'b0;
    cyc(1);
    br_valid = 1'b0;
    chk("pend_addr_held", imem_addr, 32'h104);
    chk("pend_req_held", 32'(imem_req), 32'h1);
    chk("pend_pc", pc, 32'h200);
    cyc(3);
    lat = 2;
    chk("discard_no_valid", 32'(instr_valid), 32'h0);
    chk("discard_refetch_addr", imem_addr, 32'h200);
    chk("discard_refetch_req", 32'(imem_req), 32'h1);

    // halt raised while an instruction is issued; branch while halted; resume.
    wait_valid("fetch_200");
    halt = 1'b1;
    q_instr.push_back({32'h200, 32'h211});
    instr_ready = 1'b1;
    wait_accepts(5, "accept_200");
    instr_ready = 1'b0;
    repeat (3) begin
      chk("halt_no_req", 32'(imem_req), 32'h0);
      chk("halt_no_valid", 32'(instr_valid), 32'h0);
      chk("halt_pc", pc, 32'h204);
      cyc(1);
    end
    q_br.push_back(32'h40);
    br_valid = 1'b1; br_cond = 2'd0; br_operand = 32'h5; br_target = 32'h40;
    cyc(1);
    br_valid = 1'b0;
    chk("halt_br_pc", pc, 32'h40);
    chk("halt_br_no_req", 32'(imem_req), 32'h0);
    q_addr.push_back(32'h40);
    halt = 1'b0;
    cyc(1);
    chk("resume_req", 32'(imem_req), 32'h1);
    chk("resume_addr", imem_addr, 32'h40);

    // Redirect to the top of the address space and let the PC wrap.
    wait_valid("fetch_40");
    chk("fetch_40_instr", instr, 32'h51);
    q_br.push_back(32'hFFFF_FFFC);
    q_addr.push_back(32'hFFFF_FFFC);
    br_valid = 1'b1; br_cond = 2'd2; br_operand = 32'h1; br_target = 32'hFFFF_FFFC;
    cyc(1);
    br_valid = 1'b0;
    chk("wrap_flush_valid", 32'(instr_valid), 32'h0);
    q_instr.push_back({32'hFFFF_FFFC, 32'h0000_000D});
    q_addr.push_back(32'h0);
    instr_ready = 1'b1;
    wait_accepts(6, "accept_wrap");
    chk("wrap_pc", pc, 32'h0);
    chk("wrap_addr", imem_addr, 32'h0);

    // Reset asserted mid-handshake, away from any clock edge.
    q_instr.push_back({32'h0, 32'h11});
    q_addr.push_back(32'h4);
    wait_accepts(7, "accept_0");
    lat = 50;
    cyc(2);
    chk("pre_rst_req", 32'(imem_req), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_req", 32'(imem_req), 32'h0);
    chk("async_rst_valid", 32'(instr_valid), 32'h0);
    chk("async_rst_pc", pc, 32'h0);
    chk("async_rst_addr", imem_addr, 32'h0);
    cyc(2);
    lat = 2;
    q_addr.push_back(32'h0);
    q_instr.push_back({32'h0, 32'h11});
    rst_n = 1'b1;
    cyc(2);
    halt = 1'b1;
    wait_accepts(8, "post_rst_accept");
    cyc(4);
    chk("final_halt_no_req", 32'(imem_req), 32'h0);
    chk("q_addr_drained", q_addr.size(), 32'h0);
    chk("q_instr_drained", q_instr.size(), 32'h0);
    chk("q_br_drained", q_br.size(), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1);
  end

endmodule
